hex_dump_formatter: RTL
=======================

# hex_dump_formatter

Upstream feeder for `buffered_uart_tx`. Converts a byte stream, such as USB packet bytes from the device core, into printable uppercase ASCII hex for the debug UART. Each byte becomes two hex characters plus a separator. A line ends with CR LF after `BYTES_PER_LINE` bytes or at the packet's last byte. The output drives `buffered_uart_tx` `data`/`data_valid` directly and honours its `full`.

## Interface
- `BYTES_PER_LINE`, 16: bytes printed per line before a forced CR LF; legal range 1..255.
- `SEPARATOR`, 8'h20: character emitted between bytes on a line.
- `clk`  in  1  single system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_data`  in  8  byte to print.
- `in_valid`  in  1  `in_data` valid.
- `in_last`  in  1  qualifies `in_data` as the last byte of a packet; forces CR LF after it.
- `in_ready`  out  1  block accepts a byte this cycle; transfer when `in_valid & in_ready`.
- `out_data`  out  8  ASCII character to the UART buffer `data`.
- `out_valid`  out  1  one-cycle write strobe to the UART buffer `data_valid`.
- `out_full`  in  1  UART buffer `full`.

## Operation
- States: IDLE, HI, LO, SEP, CR, LF.
- IDLE: `in_ready`=1. On transfer:
  - latch the byte and `in_last`;
  - increment the line count `lc` (width `$clog2(BYTES_PER_LINE+1)`);
  - go to HI.
- HI: emit `in_data[7:4]` as ASCII. LO: emit `in_data[3:0]` as ASCII.
- Nibble mapping: 0–9 → 8'h30–8'h39; A–F → 8'h41–8'h46 (uppercase only).
- After LO:
  - if the latched `last` is set, or `lc == BYTES_PER_LINE`, go to CR;
  - otherwise go to SEP.
- SEP emits `SEPARATOR`. CR emits 8'h0D. LF emits 8'h0A.
- After LF, `lc` clears to 0. After SEP or LF, return to IDLE.
- Each emitting state runs a send/hold sequence with a 2-bit gap counter:
  - wait until `out_full`=0;
  - pulse `out_valid` for one cycle with `out_data` set;
  - hold `out_data` unchanged for 2 further cycles;
  - advance to the next state.
- `in_ready` is 0 in every state except IDLE. It is also 0 while `rst`=1.
- `out_full` is sampled only in the cycle a strobe would be issued. It is ignored during the hold cycles.
- Simultaneous `in_last` and line-full produce a single CR LF.
- With `BYTES_PER_LINE`=1, every byte ends with CR LF and SEP is never emitted.
- Reset mid-character:
  - abandon the sequence; return to IDLE with `lc`=0;
  - no partial CR LF;
  - `out_valid` drops in the same cycle `rst` is sampled.

## Timing
- Reset values:
  - `out_data`=8'h00, `out_valid`=0;
  - `in_ready`=0 while `rst` is high, 1 in the first cycle after release;
  - state IDLE, `lc`=0.
- Byte accepted at cycle a with `out_full` low: HI strobe at a+1, LO strobe at a+4, SEP/CR strobe at a+7, LF strobe at a+10.
- Next `in_ready` is at a+10 for a SEP byte and a+13 for a CR LF byte.
- Strobe pitch is 3 cycles minimum. `out_data` is stable from the strobe cycle t through t+2.
  - Reason: the UART buffer registers `data_valid` one cycle and writes its queue at t+1; its `full` is valid by t+2.
- Stall: if `out_full`=1 at a would-be strobe cycle, no strobe is issued and the check repeats every cycle. The strobe fires in the first cycle `out_full`=0.
- Throughput is never above one character per 3 cycles, well above any UART bit rate.

## Structure
- Shared package or include `hex_fmt_defs.vh`:
  - state encodings;
  - ASCII constants for CR, LF, space, '0', 'A';
  - gap length constant (2).
- Sub-module `nibble_to_ascii`: combinational 4-bit→8-bit map, instantiated once.
- The HI/LO nibble is muxed into the sub-module's input.

## Test plan
- Reset, then one byte 8'h3C with `in_last`=1:
  - exactly four strobes: 8'h33, 8'h43, 8'h0D, 8'h0A;
  - strobes at a+1, a+4, a+7, a+10;
  - `out_data` held for 2 cycles after each strobe.
- 17 bytes 8'h00..8'h10, `in_last` only on the last:
  - "00 01 … 0F" followed by CR LF;
  - then "10" CR LF;
  - no separator before either CR.
- Hold `out_full`=1 for 20 cycles before LO of byte 8'hA5:
  - no strobe while full;
  - 8'h35 strobed in the first cycle `out_full` falls;
  - no character lost or duplicated.
- `in_valid` held high continuously:
  - `in_ready` pulses exactly once per byte;
  - the byte sequence is preserved;
  - data is never sampled in non-IDLE states.
- `rst` asserted between the HI and LO strobes:
  - `out_valid`=0 from that cycle;
  - `in_ready`=1 the cycle after release;
  - the next byte 8'hFF with `in_last` yields "FF" CR LF with `lc` restarted.
- `BYTES_PER_LINE`=1 build, bytes 8'h01, 8'h02: output "01" CR LF "02" CR LF, no 8'h20.

Source files
------------

// File: rtl/hex_dump_formatter_pkg.sv
// Shared definitions for the hex dump formatter: FSM states, ASCII constants
// and the post-strobe hold length.
package hex_dump_formatter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HI,
        ST_LO,
        ST_SEP,
        ST_CR,
        ST_LF
    } state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;

    // Cycles out_data is held after each strobe so the UART buffer's full is valid again.
    localparam logic [1:0] GAP_LEN = 2'd2;

endpackage

// File: rtl/hex_dump_formatter_nibble_to_ascii.sv
// Combinational map of one nibble to its uppercase ASCII hex digit.
module nibble_to_ascii
    import hex_dump_formatter_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        if (nibble < 4'd10) begin
            ascii = ASCII_0 + {4'h0, nibble};
        end else begin
            ascii = ASCII_A + {4'h0, nibble} - 8'd10;
        end
    end

endmodule

// File: rtl/hex_dump_formatter.sv
// Turns a byte stream into uppercase ASCII hex text for the debug UART buffer,
// one strobe per character with a fixed hold after each strobe.
module hex_dump_formatter
    import hex_dump_formatter_pkg::*;
#(
    parameter int         BYTES_PER_LINE = 16,
    parameter logic [7:0] SEPARATOR      = ASCII_SP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_full
);

    localparam int LC_W = $clog2(BYTES_PER_LINE + 1);

    state_t          state, state_nx, state_after;
    logic [1:0]      gap, gap_nx;
    logic [LC_W-1:0] lc, lc_nx;
    logic [7:0]      byte_q, byte_nx;
    logic            last_q, last_nx;
    logic            line_full;
    logic            strobe;
    logic [3:0]      nibble;
    logic [7:0]      hex_char;

    assign nibble    = (state == ST_HI) ? byte_q[7:4] : byte_q[3:0];
    assign line_full = (lc == LC_W'(BYTES_PER_LINE));

    nibble_to_ascii u_nibble_to_ascii (
        .nibble (nibble),
        .ascii  (hex_char)
    );

    // State that follows the current emitting state once its hold has elapsed.
    always_comb begin
        case (state)
            ST_HI:   state_after = ST_LO;
            ST_LO:   state_after = (last_q || line_full) ? ST_CR : ST_SEP;
            ST_CR:   state_after = ST_LF;
            default: state_after = ST_IDLE;
        endcase
    end

    // NOTE: every variable gets a default first so no path can infer a latch.
    always_comb begin
        state_nx = state;
        gap_nx   = gap;
        lc_nx    = lc;
        byte_nx  = byte_q;
        last_nx  = last_q;
        strobe   = 1'b0;

        if (state == ST_IDLE) begin
            if (in_valid) begin
                byte_nx  = in_data;
                last_nx  = in_last;
                lc_nx    = lc + LC_W'(1);
                state_nx = ST_HI;
            end
        end else if (gap == 2'd0) begin
            // out_full only matters in the cycle the strobe would go out.
            if (!out_full) begin
                strobe = 1'b1;
                gap_nx = 2'd1;
            end
        end else if (gap == GAP_LEN) begin
            gap_nx   = 2'd0;
            state_nx = state_after;
            if (state == ST_LF) begin
                lc_nx = '0;
            end
        end else begin
            gap_nx = gap + 2'd1;
        end
    end

    always_comb begin
        case (state)
            ST_HI, ST_LO: out_data = hex_char;
            ST_SEP:       out_data = SEPARATOR;
            ST_CR:        out_data = ASCII_CR;
            ST_LF:        out_data = ASCII_LF;
            default:      out_data = 8'h00;
        endcase
    end

    assign in_ready  = (state == ST_IDLE) && !rst;
    assign out_valid = strobe && !rst;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            gap    <= 2'd0;
            lc     <= '0;
            byte_q <= 8'h00;
            last_q <= 1'b0;
        end else begin
            state  <= state_nx;
            gap    <= gap_nx;
            lc     <= lc_nx;
            byte_q <= byte_nx;
            last_q <= last_nx;
        end
    end

endmodule
